edf_scheduler: RTL and testbench

- Earliest-deadline-first selector for the interrupt controller.
- Sits downstream of the per-source gateway cells, which provide a pending bit and an absolute deadline (timestamp + offset) per source.
- Scans the enabled pending sources sequentially and offers the one with the earliest deadline to the core over a valid/ready claim handshake.
- On claim, clears the source's pending bit; blocks further offers until the core signals completion (non-preemptive).

---
 rtl/edf_scheduler.sv | 96 +++++++++
 tb/tb_edf_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/edf_scheduler.sv
// Earliest-deadline-first interrupt selector: scans eligible sources one per cycle,
// offers the earliest deadline over valid/ready and holds off until completion.
module edf_scheduler #(
  parameter int NSource = 8,
  parameter int TsWidth = 64,
  parameter int IdWidth = $clog2(NSource)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NSource-1:0]         ip_i,
  input  logic [NSource-1:0]         ie_i,
  input  logic [NSource*TsWidth-1:0] dl_i,
  output logic                       irq_valid_o,
  output logic [IdWidth-1:0]         irq_id_o,
  output logic [TsWidth-1:0]         irq_dl_o,
  input  logic                       irq_ready_i,
  output logic [NSource-1:0]         ip_clr_o,
  input  logic                       cmpl_valid_i,
  input  logic [IdWidth-1:0]         cmpl_id_i,
  output logic                       busy_o
);

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, ACTIVE} state_e;

  state_e               state, state_d;
  logic [IdWidth-1:0]   idx, best_id, active_id;
  logic [TsWidth-1:0]   best_dl, cur_dl, diff;
  logic [NSource-1:0]   elig, ip_clr;
  logic                 best_valid, take, last;

  assign elig   = ip_i & ie_i;
  assign cur_dl = dl_i[idx*TsWidth +: TsWidth];
  // Wrap-aware compare: cur is earlier when (cur - best) is negative mod 2^TsWidth.
  // Ties do not take, so the lowest index keeps the slot.
  assign diff   = cur_dl - best_dl;
  assign take   = elig[idx] && (!best_valid || diff[TsWidth-1]);
  assign last   = (idx == IdWidth'(NSource - 1));

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|elig) state_d = SCAN;
      SCAN:    if (last) state_d = (take || best_valid) ? OFFER : IDLE;
      OFFER:   if (irq_ready_i) state_d = ACTIVE;
      ACTIVE:  if (cmpl_valid_i && (cmpl_id_i == active_id)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      best_valid <= 1'b0;
      best_id    <= '0;
      best_dl    <= '0;
      active_id  <= '0;
      ip_clr     <= '0;
    end else begin
      state  <= state_d;
      ip_clr <= '0;
      case (state)
        IDLE: begin
          if (|elig) begin
            idx        <= '0;
            best_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (take) begin
            best_id    <= idx;
            best_dl    <= cur_dl;
            best_valid <= 1'b1;
          end
          idx <= last ? '0 : idx + 1'b1;
        end
        OFFER: begin
          if (irq_ready_i) begin
            ip_clr    <= NSource'(1) << best_id;
            active_id <= best_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign irq_valid_o = (state == OFFER);
  assign irq_id_o    = best_id;
  assign irq_dl_o    = best_dl;
  assign ip_clr_o    = ip_clr;
  assign busy_o      = (state == ACTIVE);

endmodule

// File: tb/tb_edf_scheduler.sv
// Directed bench for edf_scheduler: stimulus pushes expected offers and clear pulses,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_edf_scheduler;

  localparam int NSource = 8;
  localparam int TsWidth = 64;
  localparam int IdWidth = 3;

  typedef struct {
    logic [IdWidth-1:0] id;
    logic [TsWidth-1:0] dl;
  } offer_t;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [NSource-1:0]             ip_i, ie_i;
  logic [NSource-1:0][TsWidth-1:0] dl;
  logic                           irq_valid_o, irq_ready_i, busy_o, cmpl_valid_i;
  logic [IdWidth-1:0]             irq_id_o, cmpl_id_i;
  logic [TsWidth-1:0]             irq_dl_o;
  logic [NSource-1:0]             ip_clr_o;

  int checks = 0;
  int failures = 0;
  offer_t             exp_offer[$];
  logic [NSource-1:0] exp_clr[$];

  edf_scheduler #(.NSource(NSource), .TsWidth(TsWidth), .IdWidth(IdWidth)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ip_i(ip_i), .ie_i(ie_i), .dl_i(dl),
    .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_dl_o(irq_dl_o),
    .irq_ready_i(irq_ready_i), .ip_clr_o(ip_clr_o),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_id_i(cmpl_id_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [TsWidth-1:0] act, input logic [TsWidth-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Monitor: compares each new offer and each clear pulse against the queues.
  logic prev_valid = 1'b0;
  always @(negedge clk_i) begin
    if (irq_valid_o && !prev_valid) begin
      if (exp_offer.size() == 0) begin
        check("unexpected_offer_id", {61'd0, irq_id_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        offer_t e;
        e = exp_offer.pop_front();
        check("offer_id", {61'd0, irq_id_o}, {61'd0, e.id});
        check("offer_dl", irq_dl_o, e.dl);
      end
    end
    prev_valid = irq_valid_o;
    if (ip_clr_o != '0) begin
      if (exp_clr.size() == 0) begin
        check("unexpected_ip_clr", {56'd0, ip_clr_o}, 64'd0);
      end else begin
        logic [NSource-1:0] c;
        c = exp_clr.pop_front();
        check("ip_clr", {56'd0, ip_clr_o}, {56'd0, c});
      end
    end
  end

  // Waits for an offer from IDLE and returns the number of edges it took.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!irq_valid_o && cnt < 50);
  endtask

  // Full offer/claim/complete cycle starting from IDLE.
  task automatic run_offer(input logic [NSource-1:0] ip, input logic [NSource-1:0] ie,
                           input logic [IdWidth-1:0] eid, input logic [TsWidth-1:0] edl);
    int cnt;
    offer_t e;
    e.id = eid;
    e.dl = edl;
    exp_offer.push_back(e);
    ip_i = ip;
    ie_i = ie;
    wait_valid(cnt);
    check("offer_latency", 64'(cnt), 64'd9);
    exp_clr.push_back(NSource'(1) << eid);
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
    ip_i = '0;
    check("busy_after_claim", {63'd0, busy_o}, 64'd1);
    check("valid_after_claim", {63'd0, irq_valid_o}, 64'd0);
    cmpl_valid_i = 1'b1;
    cmpl_id_i = eid;
    tick();
    cmpl_valid_i = 1'b0;
    check("busy_after_cmpl", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    int cnt;
    offer_t e;
    rst_i = 1'b1; ip_i = '0; ie_i = '0; dl = '0;
    irq_ready_i = 1'b0; cmpl_valid_i = 1'b0; cmpl_id_i = '0;
    tick();
    tick();
    check("rst_valid", {63'd0, irq_valid_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_clr", {56'd0, ip_clr_o}, 64'd0);
    check("rst_id", {61'd0, irq_id_o}, 64'd0);
    check("rst_dl", irq_dl_o, 64'd0);
    rst_i = 1'b0;

    // Idle with nothing pending; ready pulses without valid must do nothing.
    for (int i = 0; i < 20; i++) begin
      irq_ready_i = (i % 3 == 0);
      tick();
      check("idle_quiet", {54'd0, irq_valid_o, busy_o, ip_clr_o}, 64'd0);
    end
    irq_ready_i = 1'b0;

    // Basic: source 5 (300) beats source 2 (500).
    dl[2] = 64'd500;
    dl[5] = 64'd300;
    e.id = 3'd5; e.dl = 64'd300;
    exp_offer.push_back(e);
    ip_i = 8'b0010_0100;
    ie_i = 8'hFF;
    wait_valid(cnt);
    check("basic_latency", 64'(cnt), 64'd9);
    exp_clr.push_back(8'b0010_0000);
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
    ip_i = 8'b0000_0100;
    check("basic_busy", {63'd0, busy_o}, 64'd1);

    // Mismatched completion ignored, matching one returns to IDLE and rescans.
    cmpl_valid_i = 1'b1;
    cmpl_id_i = 3'd2;
    tick();
    cmpl_valid_i = 1'b0;
    check("bad_cmpl_busy", {63'd0, busy_o}, 64'd1);
    tick();
    check("bad_cmpl_busy2", {63'd0, busy_o}, 64'd1);
    e.id = 3'd2; e.dl = 64'd500;
    exp_offer.push_back(e);
    cmpl_valid_i = 1'b1;
    cmpl_id_i = 3'd5;
    tick();
    cmpl_valid_i = 1'b0;
    check("good_cmpl_busy", {63'd0, busy_o}, 64'd0);
    wait_valid(cnt);
    check("rescan_latency", 64'(cnt), 64'd9);
    exp_clr.push_back(8'b0000_0100);
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
    ip_i = '0;
    cmpl_valid_i = 1'b1;
    cmpl_id_i = 3'd2;
    tick();
    cmpl_valid_i = 1'b0;
    check("rescan_cmpl_busy", {63'd0, busy_o}, 64'd0);

    // Tie goes to the lower index; masking it hands the slot to the other.
    dl[1] = 64'd1000;
    dl[6] = 64'd1000;
    run_offer(8'b0100_0010, 8'hFF, 3'd1, 64'd1000);
    run_offer(8'b0100_0010, 8'b1111_1101, 3'd6, 64'd1000);

    // Wrap: 2^64-16 is earlier than 16 under modular comparison.
    dl[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    dl[3] = 64'd16;
    run_offer(8'b0000_1001, 8'hFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFF0);

    // Stability: offer holds while the source drops and an earlier one arrives.
    e.id = 3'd5; e.dl = 64'd300;
    exp_offer.push_back(e);
    ip_i = 8'b0010_0100;
    ie_i = 8'hFF;
    wait_valid(cnt);
    check("stab_latency", 64'(cnt), 64'd9);
    dl[7] = 64'd100;
    ip_i = 8'b1000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stab_valid", {63'd0, irq_valid_o}, 64'd1);
      check("stab_id", {61'd0, irq_id_o}, 64'd5);
      check("stab_dl", irq_dl_o, 64'd300);
    end

    // Reset drops the offer without any clear pulse.
    rst_i = 1'b1;
    tick();
    check("mid_rst_valid", {63'd0, irq_valid_o}, 64'd0);
    check("mid_rst_clr", {56'd0, ip_clr_o}, 64'd0);
    check("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    rst_i = 1'b0;
    ip_i = '0;
    for (int i = 0; i < 12; i++) tick();
    check("final_valid", {63'd0, irq_valid_o}, 64'd0);

    check("offers_left", 64'(exp_offer.size()), 64'd0);
    check("clrs_left", 64'(exp_clr.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
